// File: rtl/wave_sequencer.sv
// Waveform memory read sequencer: phase accumulator addressing four 128-sample
// banks, attenuation around mid-scale, and period-aligned start/stop.
module wave_sequencer #(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 10,
  parameter int IDX_BITS   = 7,
  parameter int BANK_BITS  = 2,
  parameter int MIDSCALE   = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [ACC_WIDTH-1:0]          tuning_word,
  input  logic [BANK_BITS-1:0]          wave_sel,
  input  logic [1:0]                    atten,
  output logic [BANK_BITS+IDX_BITS-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic [DATA_WIDTH-1:0]         dac_out,
  output logic                          busy,
  output logic                          period_tick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [DATA_WIDTH:0]   MID_X = (DATA_WIDTH+1)'(MIDSCALE);
  localparam logic [DATA_WIDTH-1:0] MID_W = DATA_WIDTH'(MIDSCALE);

  state_t                          state_q, state_d;
  logic [ACC_WIDTH-1:0]            acc_q, acc_d;
  logic [ACC_WIDTH-1:0]            tw_q;
  logic [BANK_BITS-1:0]            bank_q;
  logic [1:0]                      atten_q;
  logic [BANK_BITS+IDX_BITS-1:0]   addr_q, addr_d;
  logic [1:0]                      vld_pipe_q;
  logic [1:0][1:0]                 att_pipe_q;
  logic [DATA_WIDTH-1:0]           dac_q;
  logic                            busy_q, busy_d;
  logic                            tick_q, tick_d;

  logic [ACC_WIDTH:0]              sum;
  logic                            wrap, issue, reload;
  logic signed [DATA_WIDTH:0]      diff, shifted, att_word;

  assign sum  = {1'b0, acc_q} + {1'b0, tw_q};
  assign wrap = sum[ACC_WIDTH];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    issue   = 1'b0;
    reload  = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (start && tuning_word != '0) begin
          state_d = S_RUN;
          reload  = 1'b1;
        end
      end
      S_RUN: begin
        acc_d  = sum[ACC_WIDTH-1:0];
        issue  = 1'b1;
        tick_d = wrap;
        reload = wrap;
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d  = sum[ACC_WIDTH-1:0];
        tick_d = wrap;
        // A restart keeps the frozen set; otherwise the wrap ends the drain unissued.
        if (start) begin
          state_d = S_RUN;
          issue   = 1'b1;
        end else if (wrap) begin
          state_d = S_IDLE;
          acc_d   = '0;
        end else begin
          issue = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    addr_d = issue ? {bank_q, acc_d[ACC_WIDTH-1 -: IDX_BITS]} : {bank_q, {IDX_BITS{1'b0}}};
    busy_d = (state_d != S_IDLE) || (|vld_pipe_q);
  end

  assign diff     = $signed({1'b0, mem_data}) - $signed(MID_X);
  assign shifted  = diff >>> att_pipe_q[1];
  assign att_word = shifted + $signed(MID_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      tw_q       <= '0;
      bank_q     <= '0;
      atten_q    <= '0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      att_pipe_q <= '0;
      dac_q      <= MID_W;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (reload) begin
        tw_q    <= tuning_word;
        bank_q  <= wave_sel;
        atten_q <= atten;
      end
      addr_q        <= addr_d;
      vld_pipe_q    <= {vld_pipe_q[0], issue};
      att_pipe_q[0] <= atten_q;
      att_pipe_q[1] <= att_pipe_q[0];
      if (vld_pipe_q[1])
        dac_q <= att_word[DATA_WIDTH-1:0];
      else if (!busy_d)
        dac_q <= MID_W;
      busy_q <= busy_d;
      tick_q <= tick_d;
    end
  end

  assign mem_addr    = addr_q;
  assign dac_out     = dac_q;
  assign busy        = busy_q;
  assign period_tick = tick_q;

endmodule
